// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, single outstanding memory fetch, 2-entry output FIFO.
// Optional macro FETCH_PERF_EN adds the perf_stall_cnt port and its saturating stall counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic        inflight;
  logic [31:0] tag;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        fifo_mis   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  fifo_count;
  logic        pop;
  logic        issue;
  logic [2:0]  occupancy;

  assign imem_addr = pc;

  // Occupancy counts the FIFO plus the fetch still in flight, net of this cycle's pop.
  always_comb begin
    pop        = (fifo_count != 2'd0) && out_ready;
    occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    issue      = (state == RUN) && !rst && !redirect_valid && (occupancy < 3'd2);
    state_next = state;
    if (rst) begin
      state_next = RUN;
    end else if (redirect_valid) begin
      state_next = RUN;
    end else if (issue && (pc[1:0] != 2'b00)) begin
      state_next = HALT;
    end else begin
      state_next = state;
    end
  end

  always_ff @(posedge clk) begin
    state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      inflight   <= 1'b0;
      tag        <= 32'h0000_0000;
      fifo_count <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= redirect_pc;
      inflight   <= 1'b0;
      fifo_count <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc  <= pc + 32'd4;
        tag <= pc;
      end
      if (inflight) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Returned data is only captured for a fetch issued last cycle and not cancelled by redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= 32'h0000_0000;
        fifo_instr[i] <= 32'h0000_0000;
        fifo_mis[i]   <= 1'b0;
      end
    end else if (!redirect_valid && inflight) begin
      fifo_pc[wr_ptr]    <= tag;
      fifo_instr[wr_ptr] <= imem_instr;
      fifo_mis[wr_ptr]   <= (tag[1:0] != 2'b00);
    end
  end

  always_comb begin
    out_valid    = (fifo_count != 2'd0);
    out_pc       = 32'h0000_0000;
    out_instr    = 32'h0000_0000;
    out_misalign = 1'b0;
    if (out_valid) begin
      out_pc       = fifo_pc[rd_ptr];
      out_instr    = fifo_instr[rd_ptr];
      out_misalign = fifo_mis[rd_ptr];
    end else begin
      out_pc       = 32'h0000_0000;
      out_instr    = 32'h0000_0000;
      out_misalign = 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'h0000_0000;
    end else if (out_valid && !out_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs a queue-based model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misalign   (out_misalign)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // 256-byte memory; misaligned or out-of-range addresses read as 0.
  logic [31:0] mem [64];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a[1:0] != 2'b00 || a >= 32'd256) return 32'h0;
    return mem[a[7:2]];
  endfunction

  always @(posedge clk) imem_instr <= mem_read(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_halt;
  logic        m_infl;
  logic [31:0] m_tag;
  logic [31:0] m_stall;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    int   sz;
    logic p;
    logic iss;
    ent_t e;
    sz = mq.size();
    p  = (sz > 0) && rdy;
    if (r) begin
      mq.delete();
      m_pc = 32'h0; m_halt = 1'b0; m_infl = 1'b0; m_stall = 32'h0;
      return;
    end
    if (sz > 0 && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    if (p) void'(mq.pop_front());
    if (rv) begin
      mq.delete();
      m_infl = 1'b0; m_pc = rpc; m_halt = 1'b0;
      return;
    end
    iss = !m_halt && ((sz + (m_infl ? 1 : 0) - (p ? 1 : 0)) < 2);
    if (m_infl) begin
      e.pc = m_tag; e.instr = mem_read(m_tag); e.mis = (m_tag[1:0] != 2'b00);
      mq.push_back(e);
    end
    if (iss) begin
      m_tag = m_pc;
      if (m_pc[1:0] != 2'b00) m_halt = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    m_infl = iss;
  endtask

  task automatic check_outputs();
    logic        v;
    logic [31:0] epc, ein;
    logic        emis;
    v = (mq.size() > 0);
    epc = v ? mq[0].pc : 32'h0;
    ein = v ? mq[0].instr : 32'h0;
    emis = v ? mq[0].mis : 1'b0;
    check("out_valid", {31'd0, out_valid}, {31'd0, v});
    check("out_pc", out_pc, epc);
    check("out_instr", out_instr, ein);
    check("out_misalign", {31'd0, out_misalign}, {31'd0, emis});
    check("imem_addr", imem_addr, m_pc);
`ifdef FETCH_PERF_EN
    check("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
  endtask

  task automatic tick(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    check_outputs();
    model_step(r, rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        r, rv, rdy;
    logic [31:0] rpc;
    for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    model_step(1'b1, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    tick(1'b1, 1'b0, 32'h0, 1'b1);

    // Reset release: first entry two cycles later, then 0,4,8,C back to back.
    for (int k = 0; k < 6; k++) begin
      check("a_valid", {31'd0, out_valid}, (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        check("a_pc", out_pc, (k - 2) * 4);
        check("a_instr", out_instr, mem[k - 2]);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1);
    end

    // Five stall cycles: head held at 0x10.
    for (int k = 0; k < 5; k++) begin
      check("b_hold_pc", out_pc, 32'h10);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
    end

    // Redirect to 0x40 with two entries buffered.
    tick(1'b0, 1'b1, 32'h40, 1'b1);
    for (int j = 1; j <= 3; j++) begin
      check("c_valid", {31'd0, out_valid}, (j == 3) ? 32'd1 : 32'd0);
      if (j == 3) begin
        check("c_pc", out_pc, 32'h40);
`ifdef FETCH_PERF_EN
        check("c_perf", perf_stall_cnt, 32'd5);
`endif
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1);
    end

    // Misaligned redirect halts after a single entry.
    tick(1'b0, 1'b1, 32'h42, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      check("d_valid", {31'd0, out_valid}, (j == 3) ? 32'd1 : 32'd0);
      if (j == 3) begin
        check("d_pc", out_pc, 32'h42);
        check("d_mis", {31'd0, out_misalign}, 32'd1);
        check("d_instr", out_instr, 32'h0);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1);
    end
    tick(1'b0, 1'b1, 32'h80, 1'b1);
    for (int j = 1; j <= 3; j++) begin
      check("d2_valid", {31'd0, out_valid}, (j == 3) ? 32'd1 : 32'd0);
      if (j == 3) check("d2_pc", out_pc, 32'h80);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
    end

    // Reset with FIFO full and a simultaneous redirect.
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 32'h20, 1'b0);
    for (int j = 0; j <= 2; j++) begin
      check("e_valid", {31'd0, out_valid}, (j == 2) ? 32'd1 : 32'd0);
      if (j == 2) check("e_pc", out_pc, 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
    end

    // Walk past the end of memory.
    tick(1'b0, 1'b1, 32'hF8, 1'b1);
    for (int j = 1; j <= 7; j++) begin
      check("f_valid", {31'd0, out_valid}, (j >= 3) ? 32'd1 : 32'd0);
      if (j >= 3) begin
        check("f_pc", out_pc, 32'hF8 + (j - 3) * 4);
        if (j >= 5) check("f_instr", out_instr, 32'h0);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom_range(0, 72) << 2;
      if ($urandom_range(0, 7) == 0) rpc = rpc | 32'd2;
      rdy = ($urandom_range(0, 9) < 7);
      tick(r, rv, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
